// File: rtl/tile_board_sequencer.sv
// Purpose : 4x4 sliding-tile board owner: scrambles on start, applies player moves, flags a solved board.
// Latency : accepted move visible on tile_id/blank_pos 1 cycle after the pulse, won 2 cycles after.
// Backpr. : none; pulses arriving while SCRAMBLE/CHECK/WIN (or IDLE) are dropped, not queued.
//
// Ports:
//   vgaclk                          clock, all state on rising edge
//   reset                           synchronous active-high reset, wins over every input
//   start                           pulse, (re)starts a scramble from IDLE, PLAY or WIN
//   up_deb/down_deb/left_deb/right_deb  one-cycle move pulses for the blank
//   cell_row/cell_col               display read address
//   tile_id                         combinational id stored at {cell_row,cell_col} (15 = blank)
//   blank_pos                       registered cell index of the blank
//   busy / won                      high while scrambling / while the board is solved
//   move_count                      valid player moves since last scramble, saturating at 1023
//
// Build option: define SCRAMBLE_NOUNDO_EN to stop the scrambler from immediately
// undoing its previous valid move.

module tile_board_sequencer #(
   parameter int          SCRAMBLE_MOVES = 64,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
   input  logic       vgaclk,
   input  logic       reset,
   input  logic       start,
   input  logic       up_deb,
   input  logic       down_deb,
   input  logic       left_deb,
   input  logic       right_deb,
   input  logic [1:0] cell_row,
   input  logic [1:0] cell_col,
   output logic [3:0] tile_id,
   output logic [3:0] blank_pos,
   output logic       busy,
   output logic       won,
   output logic [9:0] move_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCRAMBLE,
      S_PLAY,
      S_CHECK,
      S_WIN
   } state_t;

   // Solved board: cell n holds id n (nibble n of the packed vector).
   localparam logic [15:0][3:0] IDENT = 64'hFEDC_BA98_7654_3210;

   // Returns {valid, neighbour index} for moving the blank at pos in direction dir
   // (00 up, 01 down, 10 left, 11 right). Index is don't-care when not valid.
   function automatic logic [4:0] neighbour(input logic [3:0] pos, input logic [1:0] dir);
      case (dir)
         2'b00:   return {(pos[3:2] != 2'd0), pos - 4'd4};
         2'b01:   return {(pos[3:2] != 2'd3), pos + 4'd4};
         2'b10:   return {(pos[1:0] != 2'd0), pos - 4'd1};
         default: return {(pos[1:0] != 2'd3), pos + 4'd1};
      endcase
   endfunction

   state_t            state_q, state_d;
   logic [15:0][3:0]  board_q, board_d;
   logic [3:0]        blank_q, blank_d;
   logic [15:0]       lfsr_q, lfsr_d;
   logic [9:0]        scr_cnt_q, scr_cnt_d;
   logic [9:0]        move_cnt_q, move_cnt_d;
`ifdef SCRAMBLE_NOUNDO_EN
   logic [1:0]        last_dir_q, last_dir_d;
   logic              last_vld_q, last_vld_d;
`endif

   logic [3:0]  btn_vec;
   logic        btn_one;
   logic [1:0]  btn_dir;
   logic [4:0]  ply_nb;
   logic [4:0]  scr_nb;
   logic        scr_ok;
   logic [15:0] lfsr_step;
   logic        do_swap;
   logic [3:0]  swap_idx;
   logic        go_scr;

   assign btn_vec = {right_deb, left_deb, down_deb, up_deb};
   assign btn_one = $onehot(btn_vec);

   always_comb begin
      case (btn_vec)
         4'b0001: btn_dir = 2'b00;
         4'b0010: btn_dir = 2'b01;
         4'b0100: btn_dir = 2'b10;
         default: btn_dir = 2'b11;
      endcase
   end

   assign ply_nb = neighbour(blank_q, btn_dir);
   assign scr_nb = neighbour(blank_q, lfsr_q[1:0]);

   // Galois right-shift LFSR, taps 16'hB400.
   assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ ({16{lfsr_q[0]}} & 16'hB400);

`ifdef SCRAMBLE_NOUNDO_EN
   // Flipping bit 0 of the direction code gives the opposite direction.
   assign scr_ok = scr_nb[4] && !(last_vld_q && (lfsr_q[1:0] == (last_dir_q ^ 2'b01)));
`else
   assign scr_ok = scr_nb[4];
`endif

   always_comb begin
      state_d    = state_q;
      board_d    = board_q;
      blank_d    = blank_q;
      lfsr_d     = lfsr_q;
      scr_cnt_d  = scr_cnt_q;
      move_cnt_d = move_cnt_q;
`ifdef SCRAMBLE_NOUNDO_EN
      last_dir_d = last_dir_q;
      last_vld_d = last_vld_q;
`endif
      do_swap    = 1'b0;
      swap_idx   = blank_q;
      go_scr     = 1'b0;

      case (state_q)
         S_IDLE, S_WIN: begin
            if (start) go_scr = 1'b1;
         end
         S_SCRAMBLE: begin
            lfsr_d = lfsr_step;
            // Exit is decided on the registered count, so the last valid swap
            // and the transition to PLAY land in different cycles.
            if (scr_cnt_q == 10'(SCRAMBLE_MOVES)) begin
               state_d = S_PLAY;
            end else if (scr_ok) begin
               do_swap   = 1'b1;
               swap_idx  = scr_nb[3:0];
               scr_cnt_d = scr_cnt_q + 10'd1;
`ifdef SCRAMBLE_NOUNDO_EN
               last_dir_d = lfsr_q[1:0];
               last_vld_d = 1'b1;
`endif
            end
         end
         S_PLAY: begin
            if (start) begin
               go_scr = 1'b1;
            end else if (btn_one && ply_nb[4]) begin
               do_swap  = 1'b1;
               swap_idx = ply_nb[3:0];
               if (move_cnt_q != 10'h3FF) move_cnt_d = move_cnt_q + 10'd1;
               state_d  = S_CHECK;
            end
         end
         S_CHECK: begin
            state_d = (board_q == IDENT) ? S_WIN : S_PLAY;
         end
         default: state_d = S_IDLE;
      endcase

      if (do_swap) begin
         board_d[blank_q]  = board_q[swap_idx];
         board_d[swap_idx] = 4'd15;
         blank_d           = swap_idx;
      end

      if (go_scr) begin
         board_d    = IDENT;
         blank_d    = 4'd15;
         scr_cnt_d  = 10'd0;
         move_cnt_d = 10'd0;
         state_d    = S_SCRAMBLE;
`ifdef SCRAMBLE_NOUNDO_EN
         last_vld_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge vgaclk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         board_q    <= IDENT;
         blank_q    <= 4'd15;
         lfsr_q     <= LFSR_SEED;
         scr_cnt_q  <= 10'd0;
         move_cnt_q <= 10'd0;
`ifdef SCRAMBLE_NOUNDO_EN
         last_dir_q <= 2'b00;
         last_vld_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         board_q    <= board_d;
         blank_q    <= blank_d;
         lfsr_q     <= lfsr_d;
         scr_cnt_q  <= scr_cnt_d;
         move_cnt_q <= move_cnt_d;
`ifdef SCRAMBLE_NOUNDO_EN
         last_dir_q <= last_dir_d;
         last_vld_q <= last_vld_d;
`endif
      end
   end

   assign tile_id    = board_q[{cell_row, cell_col}];
   assign blank_pos  = blank_q;
   assign busy       = (state_q == S_SCRAMBLE);
   assign won        = (state_q == S_WIN);
   assign move_count = move_cnt_q;

endmodule
